// File: rtl/frame_writer.sv
// frame_writer: collects rasterized pixels for a 64x64, 1-bpp frame into a
// one-row buffer and flushes that row to memory with a read-modify-write.
// It can also zero the whole frame on request.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   pix_valid/pix_ready      pixel handshake; pix_x selects the bit and
//                            pix_y selects the row; pix_last ends a line
//   clear_req                zero all 64 rows (honoured only when idle)
//   mem_addr/re/rdata        row read; rdata is valid one cycle after re
//   mem_we/wdata             row write
//   busy                     high whenever the block is not idle
//   done                     one-cycle pulse at the end of a line flush or a clear
module frame_writer (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    input  logic [5:0]  pix_x,
    input  logic [5:0]  pix_y,
    input  logic        pix_last,
    output logic        pix_ready,
    input  logic        clear_req,
    output logic [5:0]  mem_addr,
    output logic        mem_re,
    input  logic [63:0] mem_rdata,
    output logic        mem_we,
    output logic [63:0] mem_wdata,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RD,
        S_RDW,
        S_ACC,
        S_WB,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] buf_q, buf_d;
    logic [5:0]  buf_row_q, buf_row_d;
    logic [5:0]  tgt_q, tgt_d;       // row to fetch in the next read
    logic        dirty_q, dirty_d;
    logic        last_q, last_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        row_hit;

    assign row_hit = (pix_y == buf_row_q);
    assign busy    = (state_q != S_IDLE);

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        buf_row_d = buf_row_q;
        tgt_d     = tgt_q;
        dirty_d   = dirty_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        pix_ready = 1'b0;
        mem_addr  = 6'd0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = 64'd0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A clear wins over a pending pixel; the pixel simply waits.
                if (clear_req) begin
                    cnt_d   = 6'd0;
                    state_d = S_CLEAR;
                end else if (pix_valid) begin
                    tgt_d   = pix_y;
                    state_d = S_RD;
                end
            end
            S_CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = cnt_q;
                cnt_d    = cnt_q + 6'd1;
                if (cnt_q == 6'd63) begin
                    state_d = S_DONE;
                end
            end
            S_RD: begin
                mem_re    = 1'b1;
                mem_addr  = tgt_q;
                buf_row_d = tgt_q;
                state_d   = S_RDW;
            end
            S_RDW: begin
                buf_d   = mem_rdata;
                dirty_d = 1'b0;
                state_d = S_ACC;
            end
            S_ACC: begin
                if (pix_valid) begin
                    if (row_hit) begin
                        pix_ready    = 1'b1;
                        buf_d[pix_x] = 1'b1;
                        dirty_d      = 1'b1;
                        if (pix_last) begin
                            last_d  = 1'b1;
                            state_d = S_WB;
                        end
                    end else if (dirty_q) begin
                        // Row change: flush first; the pixel is held upstream.
                        state_d = S_WB;
                    end else begin
                        tgt_d   = pix_y;
                        state_d = S_RD;
                    end
                end
            end
            S_WB: begin
                mem_we    = 1'b1;
                mem_addr  = buf_row_q;
                mem_wdata = buf_q;
                dirty_d   = 1'b0;
                if (last_q) begin
                    state_d = S_DONE;
                end else begin
                    // pix_y is still the stalled pixel that forced this flush.
                    tgt_d   = pix_y;
                    state_d = S_RD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                last_d  = 1'b0;
                buf_d   = 64'd0;
                dirty_d = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            buf_q     <= 64'd0;
            buf_row_q <= 6'd0;
            tgt_q     <= 6'd0;
            dirty_q   <= 1'b0;
            last_q    <= 1'b0;
            cnt_q     <= 6'd0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            buf_row_q <= buf_row_d;
            tgt_q     <= tgt_d;
            dirty_q   <= dirty_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_frame_writer.sv
// Scoreboard bench for frame_writer: directed pixel/clear sequences push the
// memory reads, writes and done pulses they should cause into a queue; a
// monitor pops and compares whenever the DUT strobes memory or pulses done.
module tb_frame_writer;

    localparam int EV_RD   = 0;
    localparam int EV_WR   = 1;
    localparam int EV_DONE = 2;

    typedef struct {
        int          kind;
        logic [5:0]  addr;
        logic [63:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_valid;
    logic [5:0]  pix_x;
    logic [5:0]  pix_y;
    logic        pix_last;
    logic        pix_ready;
    logic        clear_req;
    logic [5:0]  mem_addr;
    logic        mem_re;
    logic [63:0] mem_rdata;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic        busy;
    logic        done;

    logic [63:0] mem [64];
    logic        mem_clr;
    logic        pre_we;
    logic [5:0]  pre_addr;
    logic [63:0] pre_data;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    always #5 clk = ~clk;

    frame_writer dut (
        .clk       (clk),
        .rst       (rst),
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_last  (pix_last),
        .pix_ready (pix_ready),
        .clear_req (clear_req),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done)
    );

    // Frame memory model: one-cycle read latency, write at the strobed edge.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 64'd0;
        end else if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (mem_we === 1'b1) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_re === 1'b1) begin
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void push(input int kind, input logic [5:0] a, input logic [63:0] d);
        ev_t e;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    task automatic check_ev(input int kind, input logic [5:0] a, input logic [63:0] d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected kind=%0d addr=%0d data=%0h required=none", kind, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.addr !== a || e.data !== d) begin
                failures++;
                $display("FAIL sb_event actual kind=%0d addr=%0d data=%0h required kind=%0d addr=%0d data=%0h",
                         kind, a, d, e.kind, e.addr, e.data);
            end
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            chk("re_we_exclusive", {63'd0, mem_re & mem_we}, 64'd0);
            if (mem_re === 1'b1) check_ev(EV_RD, mem_addr, 64'd0);
            if (mem_we === 1'b1) check_ev(EV_WR, mem_addr, mem_wdata);
            if (done === 1'b1) check_ev(EV_DONE, 6'd0, 64'd0);
        end
    endtask

    // Presents one pixel and returns once it is accepted; waits counts the
    // cycles pix_ready was low before acceptance.
    task automatic send_pixel(input logic [5:0] x, input logic [5:0] y, input logic last,
                              output int waits);
        logic got;
        got       = 1'b0;
        waits     = 0;
        pix_valid = 1'b1;
        pix_x     = x;
        pix_y     = y;
        pix_last  = last;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (pix_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
            waits++;
        end
        chk("pixel_accept", {63'd0, got}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        logic seen;
        seen = 1'b0;
        n    = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", {63'd0, seen}, 64'd1);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int n;
        int sum;

        rst       = 1'b1;
        pix_valid = 1'b0;
        pix_x     = 6'd0;
        pix_y     = 6'd0;
        pix_last  = 1'b0;
        clear_req = 1'b0;
        mem_clr   = 1'b1;
        pre_we    = 1'b0;
        pre_addr  = 6'd0;
        pre_data  = 64'd0;
        repeat (2) @(posedge clk);
        #1 mem_clr = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst_pix_ready", {63'd0, pix_ready}, 64'd0);
        chk("rst_mem_re",    {63'd0, mem_re},    64'd0);
        chk("rst_mem_we",    {63'd0, mem_we},    64'd0);
        chk("rst_busy",      {63'd0, busy},      64'd0);
        chk("rst_done",      {63'd0, done},      64'd0);
        chk("rst_mem_addr",  {58'd0, mem_addr},  64'd0);
        chk("rst_mem_wdata", mem_wdata,          64'd0);
        next_cycle();
        rst = 1'b0;
        fork
            monitor_loop();
        join_none

        // Single pixel (10,5), last, memory all zero.
        push(EV_RD, 6'd5, 64'd0);
        push(EV_WR, 6'd5, 64'h0000_0000_0000_0400);
        push(EV_DONE, 6'd0, 64'd0);
        send_pixel(6'd10, 6'd5, 1'b1, w);
        pix_valid = 1'b0;
        chk("t1_accept_wait", w, 3);
        wait_done(n);
        chk("t1_cycles_to_done", w + n, 5);
        next_cycle();

        // Horizontal run x=0..7 on row 3.
        push(EV_RD, 6'd3, 64'd0);
        push(EV_WR, 6'd3, 64'h0000_0000_0000_00FF);
        push(EV_DONE, 6'd0, 64'd0);
        sum = 0;
        for (int x = 0; x < 8; x++) begin
            send_pixel(6'(x), 6'd3, (x == 7), w);
            if (x == 0) chk("t2_first_wait", w, 3);
            else        sum += w;
        end
        pix_valid = 1'b0;
        chk("t2_ready_run_stalls", sum, 0);
        wait_done(n);
        chk("t2_flush_to_done", n, 2);
        next_cycle();

        // Row change with a dirty buffer: (1,2) then (1,3) last.
        mem_clr = 1'b1;
        next_cycle();
        mem_clr = 1'b0;
        push(EV_RD, 6'd2, 64'd0);
        push(EV_WR, 6'd2, 64'h2);
        push(EV_RD, 6'd3, 64'd0);
        push(EV_WR, 6'd3, 64'h2);
        push(EV_DONE, 6'd0, 64'd0);
        send_pixel(6'd1, 6'd2, 1'b0, w);
        send_pixel(6'd1, 6'd3, 1'b1, w);
        pix_valid = 1'b0;
        chk("t3_row_change_stall", w, 4);
        wait_done(n);
        next_cycle();

        // Read-modify-write keeps existing bits; a clear_req while busy is dropped.
        pre_we   = 1'b1;
        pre_addr = 6'd4;
        pre_data = 64'hF0;
        next_cycle();
        pre_we = 1'b0;
        push(EV_RD, 6'd4, 64'd0);
        push(EV_WR, 6'd4, 64'hF1);
        push(EV_DONE, 6'd0, 64'd0);
        fork
            begin
                next_cycle();
                clear_req = 1'b1;
                repeat (3) @(posedge clk);
                #1 clear_req = 1'b0;
            end
        join_none
        send_pixel(6'd0, 6'd4, 1'b1, w);
        pix_valid = 1'b0;
        wait_done(n);
        chk("t4_row4_rmw", mem[4], 64'hF1);
        next_cycle();

        // clear_req and a pixel together in idle: clear first, then the pixel.
        for (int r = 0; r < 64; r++) push(EV_WR, 6'(r), 64'd0);
        push(EV_DONE, 6'd0, 64'd0);
        push(EV_RD, 6'd9, 64'd0);
        push(EV_WR, 6'd9, 64'h80);
        push(EV_DONE, 6'd0, 64'd0);
        clear_req = 1'b1;
        fork
            begin
                next_cycle();
                clear_req = 1'b0;
            end
        join_none
        send_pixel(6'd7, 6'd9, 1'b1, w);
        pix_valid = 1'b0;
        chk("t5_wait_through_clear", w, 69);
        wait_done(n);
        chk("t5_row4_cleared", mem[4], 64'd0);
        chk("t5_row9_written", mem[9], 64'h80);
        next_cycle();

        // Reset while in WB: the WB write is seen, then everything returns to reset values.
        push(EV_RD, 6'd6, 64'd0);
        push(EV_WR, 6'd6, 64'h4);
        send_pixel(6'd2, 6'd6, 1'b1, w);
        pix_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        chk("t6_in_wb_before_rst", {63'd0, mem_we}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        chk("t6_mem_we",    {63'd0, mem_we},    64'd0);
        chk("t6_mem_re",    {63'd0, mem_re},    64'd0);
        chk("t6_busy",      {63'd0, busy},      64'd0);
        chk("t6_done",      {63'd0, done},      64'd0);
        chk("t6_pix_ready", {63'd0, pix_ready}, 64'd0);
        chk("t6_mem_addr",  {58'd0, mem_addr},  64'd0);
        chk("t6_mem_wdata", mem_wdata,          64'd0);
        next_cycle();
        rst = 1'b0;

        repeat (5) next_cycle();
        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
